// File: rtl/ahb_lite_master_pkg.sv
// Shared types and AHB-Lite encodings for the single-outstanding AHB-Lite initiator.
package ahb_lite_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    // Size 3 has no legal AHB-Lite encoding here, so it is rejected like a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case ({1'b0, size})
            HSIZE_BYTE: return 1'b0;
            HSIZE_HALF: return addr_lo[0];
            HSIZE_WORD: return (addr_lo != 2'b00);
            default:    return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: turns a req/ready/done port into SINGLE transfers.
// Optional wait-state timeout is built when AHB_LITE_MASTER_TIMEOUT_EN is defined.
module ahb_lite_master
    import ahb_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  req,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_size,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
    output logic                  timeout,
`endif
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("ahb_lite_master: TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic [1:0]            htrans_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic [DATA_WIDTH-1:0] wdata_q;

`ifdef AHB_LITE_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             timeout_q;
`endif

    // NOTE: every register in this block uses <= so all state updates see the same
    // pre-edge values; later assignments in the block intentionally override earlier ones.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= HSIZE_BYTE;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= '0;
            wdata_q  <= '0;
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (req) begin
                        ready_q <= 1'b0;
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            state_q <= RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            state_q  <= ADDR;
                            htrans_q <= HTRANS_NONSEQ;
                            haddr_q  <= req_addr;
                            hwrite_q <= req_write;
                            hsize_q  <= {1'b0, req_size};
                            wdata_q  <= req_wdata;
                        end
                    end
                end
                ADDR: begin
                    if (HREADY) begin
                        state_q  <= DATA;
                        htrans_q <= HTRANS_IDLE;
                        if (hwrite_q) hwdata_q <= wdata_q;
                    end
                end
                DATA: begin
                    // An ERROR response must not overwrite the last good read data.
                    if (HREADY) begin
                        state_q <= RESP;
                        done_q  <= 1'b1;
                        err_q   <= HRESP;
                        if (!hwrite_q && !HRESP) rdata_q <= HRDATA;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
            // Abort overrides the case above; the counter is zero whenever a new ADDR begins.
            if ((state_q == ADDR || state_q == DATA) && !HREADY) begin
                if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_q    <= RESP;
                    htrans_q   <= HTRANS_IDLE;
                    done_q     <= 1'b1;
                    err_q      <= 1'b1;
                    timeout_q  <= 1'b1;
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end
            end else begin
                wait_cnt_q <= '0;
            end
`endif
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HTRANS    = htrans_q;
    assign HWDATA    = hwdata_q;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: outputs sampled and inputs driven on the falling edge,
// so "cycle k" below is the period after rising edge k.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        req;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic        err;
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
    logic        timeout;
`endif
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int passed = 0;
    int total  = 0;

    ahb_lite_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .req      (req),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_size (req_size),
        .req_wdata(req_wdata),
        .ready    (ready),
        .done     (done),
        .rdata    (rdata),
        .err      (err),
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
        .timeout  (timeout),
`endif
        .HADDR    (HADDR),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HTRANS   (HTRANS),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HMASTLOCK(HMASTLOCK),
        .HWDATA   (HWDATA),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    task automatic test_reset();
        n_rst = 1'b0; req = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rdata); else passed++;
        total++; if (HTRANS !== 2'b00) $display("FAIL rst_htrans: got %b want 00", HTRANS); else passed++;
        total++; if (HADDR !== 32'h0) $display("FAIL rst_haddr: got %h want 0", HADDR); else passed++;
        total++; if (HWRITE !== 1'b0) $display("FAIL rst_hwrite: got %b want 0", HWRITE); else passed++;
        total++; if (HSIZE !== 3'b000) $display("FAIL rst_hsize: got %b want 000", HSIZE); else passed++;
        total++; if (HWDATA !== 32'h0) $display("FAIL rst_hwdata: got %h want 0", HWDATA); else passed++;
        total++; if (HBURST !== 3'b000) $display("FAIL rst_hburst: got %b want 000", HBURST); else passed++;
        total++; if (HPROT !== 4'b0011) $display("FAIL rst_hprot: got %b want 0011", HPROT); else passed++;
        total++; if (HMASTLOCK !== 1'b0) $display("FAIL rst_hmastlock: got %b want 0", HMASTLOCK); else passed++;
        n_rst = 1'b1;
        @(negedge clk);
        total++; if (ready !== 1'b1) $display("FAIL rst_ready_after: got %b want 1", ready); else passed++;
    endtask

    task automatic test_read_word();
        @(negedge clk);
        req = 1'b1; req_write = 1'b0; req_addr = 32'h8004_0004; req_size = 2'd2; HRDATA = 32'h7;
        @(negedge clk);  // cycle 1: address phase
        req = 1'b0;
        total++; if (HTRANS !== 2'b10) $display("FAIL rd_htrans_c1: got %b want 10", HTRANS); else passed++;
        total++; if (HADDR !== 32'h8004_0004) $display("FAIL rd_haddr_c1: got %h want 80040004", HADDR); else passed++;
        total++; if (HSIZE !== 3'b010) $display("FAIL rd_hsize_c1: got %b want 010", HSIZE); else passed++;
        total++; if (HWRITE !== 1'b0) $display("FAIL rd_hwrite_c1: got %b want 0", HWRITE); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL rd_ready_c1: got %b want 0", ready); else passed++;
        @(negedge clk);  // cycle 2: data phase
        total++; if (HTRANS !== 2'b00) $display("FAIL rd_htrans_c2: got %b want 00", HTRANS); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rd_done_c2: got %b want 0", done); else passed++;
        @(negedge clk);  // cycle 3: response
        total++; if (done !== 1'b1) $display("FAIL rd_done_c3: got %b want 1", done); else passed++;
        total++; if (rdata !== 32'h7) $display("FAIL rd_rdata_c3: got %h want 7", rdata); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rd_err_c3: got %b want 0", err); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL rd_done_c4: got %b want 0", done); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL rd_ready_c4: got %b want 1", ready); else passed++;
    endtask

    task automatic test_write_wait();
        @(negedge clk);
        req = 1'b1; req_write = 1'b1; req_addr = 32'h8004_0010; req_size = 2'd2; req_wdata = 32'hDEAD_BEEF;
        HRDATA = 32'h5555_5555;
        @(negedge clk);  // cycle 1
        req = 1'b0; req_wdata = 32'h0;
        total++; if (HTRANS !== 2'b10) $display("FAIL wr_htrans_c1: got %b want 10", HTRANS); else passed++;
        total++; if (HWRITE !== 1'b1) $display("FAIL wr_hwrite_c1: got %b want 1", HWRITE); else passed++;
        total++; if (HADDR !== 32'h8004_0010) $display("FAIL wr_haddr_c1: got %h want 80040010", HADDR); else passed++;
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);  // cycles 2..4: data phase, two wait states then ready
            HREADY = (c == 4);
            total++; if (HWDATA !== 32'hDEAD_BEEF) $display("FAIL wr_hwdata_c%0d: got %h want deadbeef", c, HWDATA); else passed++;
            total++; if (done !== 1'b0) $display("FAIL wr_done_c%0d: got %b want 0", c, done); else passed++;
            total++; if (HTRANS !== 2'b00) $display("FAIL wr_htrans_c%0d: got %b want 00", c, HTRANS); else passed++;
        end
        @(negedge clk);  // cycle 5
        total++; if (done !== 1'b1) $display("FAIL wr_done_c5: got %b want 1", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL wr_err_c5: got %b want 0", err); else passed++;
        total++; if (rdata !== 32'h7) $display("FAIL wr_rdata_kept: got %h want 7", rdata); else passed++;
        @(negedge clk);
        total++; if (ready !== 1'b1) $display("FAIL wr_ready_c6: got %b want 1", ready); else passed++;
    endtask

    task automatic test_read_error();
        @(negedge clk);
        req = 1'b1; req_write = 1'b0; req_addr = 32'h8004_0008; req_size = 2'd2; HRDATA = 32'hAAAA_5555;
        @(negedge clk);  // cycle 1
        req = 1'b0;
        total++; if (HTRANS !== 2'b10) $display("FAIL er_htrans_c1: got %b want 10", HTRANS); else passed++;
        @(negedge clk);  // cycle 2: first error cycle
        HRESP = 1'b1; HREADY = 1'b0;
        total++; if (HTRANS !== 2'b00) $display("FAIL er_htrans_c2: got %b want 00", HTRANS); else passed++;
        @(negedge clk);  // cycle 3: second error cycle
        HREADY = 1'b1;
        total++; if (HTRANS !== 2'b00) $display("FAIL er_htrans_c3: got %b want 00", HTRANS); else passed++;
        total++; if (done !== 1'b0) $display("FAIL er_done_c3: got %b want 0", done); else passed++;
        @(negedge clk);  // cycle 4
        HRESP = 1'b0;
        total++; if (done !== 1'b1) $display("FAIL er_done_c4: got %b want 1", done); else passed++;
        total++; if (err !== 1'b1) $display("FAIL er_err_c4: got %b want 1", err); else passed++;
        total++; if (rdata !== 32'h7) $display("FAIL er_rdata_kept: got %h want 7", rdata); else passed++;
        @(negedge clk);
        total++; if (ready !== 1'b1) $display("FAIL er_ready_c5: got %b want 1", ready); else passed++;
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [3];
        logic [31:0] addrs [3];
        sizes = '{2'd1, 2'd3, 2'd2};
        addrs = '{32'h8004_0001, 32'h8004_0000, 32'h8004_0002};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            req = 1'b1; req_write = 1'b0; req_addr = addrs[v]; req_size = sizes[v];
            @(negedge clk);  // cycle 1: straight to response
            req = 1'b0;
            total++; if (HTRANS !== 2'b00) $display("FAIL mis%0d_htrans_c1: got %b want 00", v, HTRANS); else passed++;
            total++; if (done !== 1'b1) $display("FAIL mis%0d_done_c1: got %b want 1", v, done); else passed++;
            total++; if (err !== 1'b1) $display("FAIL mis%0d_err_c1: got %b want 1", v, err); else passed++;
            @(negedge clk);
            total++; if (HTRANS !== 2'b00) $display("FAIL mis%0d_htrans_c2: got %b want 00", v, HTRANS); else passed++;
            total++; if (ready !== 1'b1) $display("FAIL mis%0d_ready_c2: got %b want 1", v, ready); else passed++;
            total++; if (rdata !== 32'h7) $display("FAIL mis%0d_rdata: got %h want 7", v, rdata); else passed++;
        end
        // A byte access at an odd address is legal and must reach the bus.
        @(negedge clk);
        req = 1'b1; req_addr = 32'h8004_0003; req_size = 2'd0; HRDATA = 32'h33;
        @(negedge clk);
        req = 1'b0;
        total++; if (HTRANS !== 2'b10) $display("FAIL byte_htrans_c1: got %b want 10", HTRANS); else passed++;
        total++; if (HSIZE !== 3'b000) $display("FAIL byte_hsize_c1: got %b want 000", HSIZE); else passed++;
        repeat (2) @(negedge clk);
        total++; if (done !== 1'b1) $display("FAIL byte_done_c3: got %b want 1", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL byte_err_c3: got %b want 0", err); else passed++;
        total++; if (rdata !== 32'h33) $display("FAIL byte_rdata_c3: got %h want 33", rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_htrans [5];
        logic       exp_done   [5];
        logic       exp_ready  [5];
        exp_htrans = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
        exp_done   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_ready  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        req = 1'b1; req_write = 1'b0; req_addr = 32'h8004_0040; req_size = 2'd2; HRDATA = 32'h1111;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2) req_addr = 32'h8004_0080;
            if (c == 5) req = 1'b0;
            total++; if (HTRANS !== exp_htrans[c-1]) $display("FAIL b2b_htrans_c%0d: got %b want %b", c, HTRANS, exp_htrans[c-1]); else passed++;
            total++; if (done !== exp_done[c-1]) $display("FAIL b2b_done_c%0d: got %b want %b", c, done, exp_done[c-1]); else passed++;
            total++; if (ready !== exp_ready[c-1]) $display("FAIL b2b_ready_c%0d: got %b want %b", c, ready, exp_ready[c-1]); else passed++;
            if (c == 3) begin
                total++; if (HADDR !== 32'h8004_0040) $display("FAIL b2b_haddr_c3: got %h want 80040040", HADDR); else passed++;
            end
            if (c == 5) begin
                total++; if (HADDR !== 32'h8004_0080) $display("FAIL b2b_haddr_c5: got %h want 80040080", HADDR); else passed++;
            end
        end
        HRDATA = 32'h2222;
        repeat (2) @(negedge clk);  // cycle 7: second response
        total++; if (done !== 1'b1) $display("FAIL b2b_done_c7: got %b want 1", done); else passed++;
        total++; if (rdata !== 32'h2222) $display("FAIL b2b_rdata_c7: got %h want 2222", rdata); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_transfer();
        @(negedge clk);
        req = 1'b1; req_write = 1'b0; req_addr = 32'h8004_0020; req_size = 2'd2;
        @(negedge clk);  // cycle 1: stray request while busy
        req_write = 1'b1; req_addr = 32'h8004_00F0;
        @(negedge clk);  // cycle 2: stall the data phase
        req = 1'b0; HREADY = 1'b0;
        total++; if (HTRANS !== 2'b00) $display("FAIL rm_htrans_c2: got %b want 00", HTRANS); else passed++;
        total++; if (HADDR !== 32'h8004_0020) $display("FAIL rm_haddr_c2: got %h want 80040020", HADDR); else passed++;
        #1 n_rst = 1'b0;
        #1;
        total++; if (ready !== 1'b1) $display("FAIL rm_ready: got %b want 1", ready); else passed++;
        total++; if (done !== 1'b0) $display("FAIL rm_done: got %b want 0", done); else passed++;
        total++; if (err !== 1'b0) $display("FAIL rm_err: got %b want 0", err); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL rm_rdata: got %h want 0", rdata); else passed++;
        total++; if (HADDR !== 32'h0) $display("FAIL rm_haddr: got %h want 0", HADDR); else passed++;
        total++; if (HWDATA !== 32'h0) $display("FAIL rm_hwdata: got %h want 0", HWDATA); else passed++;
        total++; if (HSIZE !== 3'b000) $display("FAIL rm_hsize: got %b want 000", HSIZE); else passed++;
        @(negedge clk);
        n_rst = 1'b1; HREADY = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if ({done, ready, HTRANS} !== 4'b0100) $display("FAIL rm_idle_%0d: done/ready/htrans got %b want 0100", c, {done, ready, HTRANS}); else passed++;
        end
    endtask

`ifdef AHB_LITE_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk);
        req = 1'b1; req_write = 1'b0; req_addr = 32'h8004_0000; req_size = 2'd2; HREADY = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            req = 1'b0;
            total++; if (HTRANS !== 2'b10) $display("FAIL to_htrans_c%0d: got %b want 10", c, HTRANS); else passed++;
            total++; if (done !== 1'b0) $display("FAIL to_done_c%0d: got %b want 0", c, done); else passed++;
        end
        @(negedge clk);  // cycle 5
        HREADY = 1'b1;
        total++; if (done !== 1'b1) $display("FAIL to_done_c5: got %b want 1", done); else passed++;
        total++; if (err !== 1'b1) $display("FAIL to_err_c5: got %b want 1", err); else passed++;
        total++; if (timeout !== 1'b1) $display("FAIL to_timeout_c5: got %b want 1", timeout); else passed++;
        total++; if (HTRANS !== 2'b00) $display("FAIL to_htrans_c5: got %b want 00", HTRANS); else passed++;
        @(negedge clk);
        total++; if (timeout !== 1'b0) $display("FAIL to_timeout_c6: got %b want 0", timeout); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL to_ready_c6: got %b want 1", ready); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_read_word();
        test_write_wait();
        test_read_error();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_transfer();
`ifdef AHB_LITE_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
